// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes the async bit clock, word select and data into clk,
// deserializes left/right words and presents the upper OUT_W bits as a stereo pair.
module i2s_rx #(
  parameter int unsigned SMPL_W = 24,
  parameter int unsigned OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    I2S_sclk,
  input  logic                    I2S_ws,
  input  logic                    I2S_data,
  output logic signed [OUT_W-1:0] lft_chnnl,
  output logic signed [OUT_W-1:0] rght_chnnl,
  output logic                    vld
);

  localparam int unsigned CNT_W  = $clog2(SMPL_W + 1);
  localparam int unsigned SYNC_W = 3;

  typedef enum logic [2:0] {
    SYNC      = 3'd0,
    LFT_SHFT  = 3'd1,
    LFT_WAIT  = 3'd2,
    RGHT_SHFT = 3'd3,
    RGHT_WAIT = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_W-1:0] r_sclk_ff;
  logic [SYNC_W-1:0] r_ws_ff;
  logic [SYNC_W-1:0] r_data_ff;
  logic              r_sclk_prev;
  logic              r_ws_prev;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [SMPL_W-2:0] r_shreg;
  logic [OUT_W-1:0]  r_lft_hold;

  logic              w_sclk_s;
  logic              w_ws_s;
  logic              w_data_s;
  logic              w_rise;
  logic              w_ws_fall;
  logic              w_ws_rise;
  logic              w_ws_chg;
  logic              w_word_done;
  logic [SMPL_W-1:0] w_shift_nxt;
  logic [OUT_W-1:0]  w_word_top;

  logic              w_shift;
  logic              w_cnt_clr;
  logic              w_lft_latch;
  logic              w_rght_done;

  assign w_sclk_s    = r_sclk_ff[SYNC_W-1];
  assign w_ws_s      = r_ws_ff[SYNC_W-1];
  assign w_data_s    = r_data_ff[SYNC_W-1];
  assign w_rise      = w_sclk_s & ~r_sclk_prev;
  assign w_ws_fall   = w_rise & r_ws_prev & ~w_ws_s;
  assign w_ws_rise   = w_rise & ~r_ws_prev & w_ws_s;
  assign w_ws_chg    = w_rise & (r_ws_prev ^ w_ws_s);
  assign w_word_done = (r_bit_cnt == CNT_W'(SMPL_W - 1));
  assign w_shift_nxt = {r_shreg, w_data_s};
  assign w_word_top  = w_shift_nxt[SMPL_W-1 -: OUT_W];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= SYNC;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a ws edge inside a shift state means the frame was short
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SYNC:      if (w_ws_fall) w_state_nxt = LFT_SHFT;
      LFT_SHFT:  if (w_ws_chg) w_state_nxt = SYNC;
                 else if (w_rise && w_word_done) w_state_nxt = LFT_WAIT;
      LFT_WAIT:  if (w_ws_rise) w_state_nxt = RGHT_SHFT;
      RGHT_SHFT: if (w_ws_chg) w_state_nxt = SYNC;
                 else if (w_rise && w_word_done) w_state_nxt = RGHT_WAIT;
      RGHT_WAIT: if (w_ws_fall) w_state_nxt = LFT_SHFT;
      default:   w_state_nxt = SYNC;
    endcase
  end

  // Datapath controls decoded from the current state
  always_comb begin
    w_shift     = 1'b0;
    w_cnt_clr   = 1'b0;
    w_lft_latch = 1'b0;
    w_rght_done = 1'b0;
    case (r_state)
      LFT_SHFT, RGHT_SHFT: begin
        if (w_ws_chg) begin
          w_cnt_clr = 1'b1;
        end else if (w_rise) begin
          w_shift = 1'b1;
          if (w_word_done) begin
            w_cnt_clr = 1'b1;
            if (r_state == LFT_SHFT) w_lft_latch = 1'b1;
            else                     w_rght_done = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Synchronizers, edge history, shifter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_ff   <= '0;
      r_ws_ff     <= '0;
      r_data_ff   <= '0;
      r_sclk_prev <= 1'b0;
      r_ws_prev   <= 1'b0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_lft_hold  <= '0;
      lft_chnnl   <= '0;
      rght_chnnl  <= '0;
      vld         <= 1'b0;
    end else begin
      r_sclk_ff   <= {r_sclk_ff[SYNC_W-2:0], I2S_sclk};
      r_ws_ff     <= {r_ws_ff[SYNC_W-2:0], I2S_ws};
      r_data_ff   <= {r_data_ff[SYNC_W-2:0], I2S_data};
      r_sclk_prev <= w_sclk_s;
      if (w_rise) r_ws_prev <= w_ws_s;
      if (w_cnt_clr)
        r_bit_cnt <= '0;
      else if (w_shift && (r_bit_cnt != CNT_W'(SMPL_W)))
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      if (w_shift)     r_shreg    <= w_shift_nxt[SMPL_W-2:0];
      if (w_lft_latch) r_lft_hold <= w_word_top;
      vld <= w_rght_done;
      if (w_rght_done) begin
        rght_chnnl <= w_word_top;
        lft_chnnl  <= r_lft_hold;
      end
    end
  end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter SMPL_W, default 24: I2S sample bits captured per channel, MSB first.
REQ-002 Parameter OUT_W, default 16: output sample width; the upper OUT_W bits of each SMPL_W sample are kept.
REQ-003 clk  input  1  system clock; the block's only clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 I2S_sclk  input  1  I2S bit clock, asynchronous to clk, at most clk/8.
REQ-006 I2S_ws  input  1  word select, asynchronous; 0 = left, 1 = right.
REQ-007 I2S_data  input  1  serial data, asynchronous; sampled on I2S_sclk rising edges.
REQ-008 lft_chnnl  output  OUT_W  signed left sample (two's complement).
REQ-009 rght_chnnl  output  OUT_W  signed right sample (two's complement).
REQ-010 vld  output  1  one-clk pulse; lft_chnnl and rght_chnnl hold a new stereo pair.

Function
REQ-011 I2S_sclk, I2S_ws and I2S_data SHALL each pass through a 3-flop synchronizer; all logic SHALL use only the third-stage outputs (sclk_s, ws_s, data_s).
REQ-012 A rise event SHALL be one clk cycle in which sclk_s=1 and the previous sclk_s=0; ws_s and data_s are sampled only in rise cycles.
REQ-013 ws_prev SHALL hold ws_s from the last rise. A ws fall is a rise with ws_prev=1 and ws_s=0; a ws rise is a rise with ws_prev=0 and ws_s=1.
REQ-014 The FSM states SHALL be SYNC, LFT_SHFT, LFT_WAIT, RGHT_SHFT and RGHT_WAIT; the reset state is SYNC.
REQ-015 SYNC -> LFT_SHFT on a ws fall. The data bit sampled in that rise is the previous slot's LSB and SHALL be discarded (one-bit I2S delay).
REQ-016 LFT_SHFT: on each rise, shift data_s into the shift register LSB and increment bit_cnt. After SMPL_W bits, latch the upper OUT_W bits into lft_hold, clear bit_cnt and go to LFT_WAIT.
REQ-017 LFT_WAIT: ignore bits until a ws rise, then go to RGHT_SHFT and discard that rise's bit. Slots longer than SMPL_W bits (e.g. 32) are therefore legal.
REQ-018 RGHT_SHFT: shift as in LFT_SHFT. After SMPL_W bits, in the following clk SHALL:
  - load rght_chnnl with the upper OUT_W bits;
  - load lft_chnnl with lft_hold;
  - pulse vld for exactly one clk;
  - go to RGHT_WAIT.
REQ-019 RGHT_WAIT -> LFT_SHFT on a ws fall; that rise's bit is discarded.
REQ-020 A ws transition while in LFT_SHFT or RGHT_SHFT before SMPL_W bits are collected (short frame) SHALL force SYNC and clear bit_cnt. No vld is produced for that frame, and the outputs keep their prior values.
REQ-021 Latency: vld SHALL assert exactly 1 clk after the clk cycle in which the rise carrying the SMPL_W-th right bit is detected.
REQ-022 lft_chnnl and rght_chnnl SHALL change only in the vld cycle and hold until the next vld.
REQ-023 vld SHALL never assert in two consecutive clk cycles.
REQ-024 bit_cnt SHALL be ceil(log2(SMPL_W+1)) bits wide and SHALL NOT wrap.

Reset
REQ-025 While rst=1 at a clk edge, the block SHALL:
  - set the FSM to SYNC;
  - clear all synchronizer flops, sclk/ws history, bit_cnt, the shift register and lft_hold;
  - drive lft_chnnl=0, rght_chnnl=0, vld=0.
REQ-026 A reset mid-frame SHALL discard the partial frame. The first vld after reset SHALL require a complete ws fall, then left word, then right word sequence.

Verification
REQ-027 Reset check: hold rst=1 for 2 clk with I2S toggling -> lft_chnnl=0, rght_chnnl=0, vld=0, FSM in SYNC.
REQ-028 Basic frame: 64-sclk frames at clk/16, left 24'h123456, right 24'hABCDEF -> one vld per frame with lft_chnnl=16'h1234 and rght_chnnl=16'hABCD.
REQ-029 Extremes: left 24'h7FFFFF, right 24'h800000 -> lft_chnnl=16'h7FFF, rght_chnnl=16'h8000; vld pulses exactly 1 clk wide, 1 clk after the last right-bit rise.
REQ-030 Short frame: ws toggles after 10 left bits -> no vld for that frame and outputs unchanged. The next full frame (24'h00FF00 / 24'h0000FF) -> vld with 16'h00FF / 16'h0000.
REQ-031 Mid-frame reset: assert rst during right bit 12 -> outputs go to 0. The partial frame gives no vld. The first vld comes only after the next ws fall and a full left plus right word.
REQ-032 Start-up alignment: stimulus begins with ws=0 mid-left-word -> no vld until a ws fall is observed. Thereafter one vld per frame over 100 random frames, each matching the scoreboard.
